// File: rtl/jump_pkg.sv
// jump_pkg: shared state type and kinematic constants for the jump and free-fall stages
package jump_pkg;
  typedef enum logic [1:0] {GROUND, RISE, HANDOFF, WAIT_LAND} state_t;
  localparam int W_DEF = 9;
  localparam int G_DEF = 14;
  localparam int G_HALF = G_DEF / 2;
  localparam int V_JUMP_DEF = 56;
  localparam int Y_CEIL_DEF = 400;
  localparam int COOLDOWN_DEF = 4;
endpackage

// File: rtl/jump_rise_if.sv
// jump_rise_if: apex handoff from the jump stage to the free-fall stage
interface jump_rise_if #(parameter int W = jump_pkg::W_DEF);
  logic fall_valid;
  logic fall_ready;
  logic [W-1:0] y;
  logic [W-1:0] v;
  modport master (output fall_valid, y, v, input fall_ready);
  modport slave (input fall_valid, y, v, output fall_ready);
endinterface

// File: rtl/kin_step.sv
// kin_step: one rising integration step with ceiling and apex detection
module kin_step import jump_pkg::*; #(
  parameter int W = W_DEF,
  parameter int G = G_DEF,
  parameter int GH = G_HALF,
  parameter int Y_CEIL = Y_CEIL_DEF
) (
  input  logic [W-1:0] y,
  input  logic [W-1:0] v,
  output logic [W-1:0] y_n,
  output logic [W-1:0] v_n,
  output logic         ceil_hit,
  output logic         apex
);
  logic [W:0] sum;
  assign sum = {1'b0, y} + {v[W-1], v} - (W+1)'(GH);
  assign y_n = sum[W-1:0];
  assign v_n = v - W'(G);
  assign ceil_hit = sum > (W+1)'(Y_CEIL);
  assign apex = $signed(v_n) <= $signed(W'(G));
endmodule

// File: rtl/jump_rise.sv
// jump_rise: jump launch FSM integrating the rising arc and handing the apex to free fall
module jump_rise import jump_pkg::*; #(
  parameter int W = W_DEF,
  parameter int G = G_DEF,
  parameter int V_JUMP = V_JUMP_DEF,
  parameter int Y_CEIL = Y_CEIL_DEF,
  parameter int COOLDOWN = COOLDOWN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         jump_req,
  input  logic [W-1:0] y_ground,
  input  logic         land,
  jump_rise_if.master  fall,
  output logic         airborne,
  output logic         rising
);
  localparam int CW = $clog2(COOLDOWN + 2);
  state_t state;
  logic [W-1:0] y_q, v_q, y_n, v_n;
  logic [CW-1:0] cooldown;
  logic jump_q, pending, accept, go, ceil_hit, apex;
  kin_step #(.W(W), .G(G), .GH(G / 2), .Y_CEIL(Y_CEIL)) u_kin (
    .y(y_q), .v(v_q), .y_n(y_n), .v_n(v_n), .ceil_hit(ceil_hit), .apex(apex)
  );
  assign accept = jump_req & ~jump_q & (cooldown == '0);
  assign go = tick & (pending | accept);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= GROUND;
      y_q <= '0;
      v_q <= '0;
      pending <= 1'b0;
      cooldown <= '0;
      jump_q <= 1'b1;
    end else begin
      jump_q <= jump_req;
      case (state)
        GROUND: begin
          y_q <= y_ground;
          v_q <= go ? W'(V_JUMP) : '0;
          pending <= ~go & (pending | accept);
          if (tick && cooldown != '0) cooldown <= cooldown - CW'(1);
          if (go) state <= RISE;
        end
        RISE: if (tick) begin
          y_q <= ceil_hit ? W'(Y_CEIL) : y_n;
          v_q <= ceil_hit ? '0 : v_n;
          if (ceil_hit || apex) state <= HANDOFF;
        end
        HANDOFF: if (fall.fall_ready) state <= WAIT_LAND;
        WAIT_LAND: if (land) begin
          state <= GROUND;
          cooldown <= CW'(COOLDOWN);
        end
        default: state <= GROUND;
      endcase
    end
  assign fall.fall_valid = state == HANDOFF;
  assign fall.y = y_q;
  assign fall.v = v_q;
  assign airborne = state != GROUND;
  assign rising = state == RISE;
endmodule

// File: tb/tb_jump_rise.sv
// tb_jump_rise: vector table with expectation queue for the jump launch controller
module tb_jump_rise;
  typedef struct {
    logic [8:0] yg;
    logic jr, tk, ld, rdy;
    logic [8:0] ey, ev;
    logic efv, eair, erise;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, jump_req = 1'b1, land = 1'b0;
  logic [8:0] y_ground = 9'd33;
  logic air0, rise0, air1, rise1;
  int n_chk = 0, n_fail = 0;
  vec_t sb[$];
  vec_t tbl[25];

  jump_rise_if f0();
  jump_rise_if f1();

  jump_rise u0 (.clk(clk), .rst_n(rst_n), .tick(tick), .jump_req(jump_req), .y_ground(y_ground),
                .land(land), .fall(f0), .airborne(air0), .rising(rise0));
  jump_rise #(.Y_CEIL(100)) u1 (.clk(clk), .rst_n(rst_n), .tick(tick), .jump_req(jump_req),
                .y_ground(y_ground), .land(land), .fall(f1), .airborne(air1), .rising(rise1));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [8:0] yg, logic jr, logic tk, logic ld, logic rdy,
                              logic [8:0] ey, logic [8:0] ev, logic efv, logic eair, logic erise);
    mk = '{yg, jr, tk, ld, rdy, ey, ev, efv, eair, erise};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    vec_t e;
    @(negedge clk);
    y_ground = t.yg;
    jump_req = t.jr;
    tick = t.tk;
    land = t.ld;
    f0.fall_ready = t.rdy;
    f1.fall_ready = t.rdy;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".y"}, 16'(f0.y), 16'(e.ey));
    chk({tag, ".v"}, 16'(f0.v), 16'(e.ev));
    chk({tag, ".fall_valid"}, 16'(f0.fall_valid), 16'(e.efv));
    chk({tag, ".airborne"}, 16'(air0), 16'(e.eair));
    chk({tag, ".rising"}, 16'(rise0), 16'(e.erise));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    jump_req = 1'b0;
    tick = 1'b0;
    land = 1'b0;
    f0.fall_ready = 1'b0;
    f1.fall_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    f0.fall_ready = 1'b0;
    f1.fall_ready = 1'b0;
    tbl[0]  = mk(20, 0, 0, 0, 0,  20,  0, 0, 0, 0);
    tbl[1]  = mk(20, 1, 0, 0, 0,  20,  0, 0, 0, 0);
    tbl[2]  = mk(20, 0, 1, 0, 0,  20, 56, 0, 1, 1);
    tbl[3]  = mk(20, 0, 0, 0, 0,  20, 56, 0, 1, 1);
    tbl[4]  = mk(20, 0, 1, 0, 0,  69, 42, 0, 1, 1);
    tbl[5]  = mk(20, 0, 1, 0, 0, 104, 28, 0, 1, 1);
    tbl[6]  = mk(20, 0, 1, 0, 0, 125, 14, 1, 1, 0);
    tbl[7]  = mk(20, 0, 1, 0, 0, 125, 14, 1, 1, 0);
    tbl[8]  = mk(20, 0, 1, 1, 0, 125, 14, 1, 1, 0);
    tbl[9]  = mk(20, 0, 0, 0, 0, 125, 14, 1, 1, 0);
    tbl[10] = mk(20, 1, 1, 0, 0, 125, 14, 1, 1, 0);
    tbl[11] = mk(20, 0, 0, 0, 1, 125, 14, 0, 1, 0);
    tbl[12] = mk(25, 0, 1, 0, 0, 125, 14, 0, 1, 0);
    tbl[13] = mk(25, 0, 0, 1, 0, 125, 14, 0, 0, 0);
    tbl[14] = mk(25, 1, 1, 0, 0,  25,  0, 0, 0, 0);
    tbl[15] = mk(25, 0, 0, 0, 0,  25,  0, 0, 0, 0);
    tbl[16] = mk(25, 1, 1, 0, 0,  25,  0, 0, 0, 0);
    tbl[17] = mk(25, 0, 0, 0, 0,  25,  0, 0, 0, 0);
    tbl[18] = mk(25, 1, 1, 0, 0,  25,  0, 0, 0, 0);
    tbl[19] = mk(25, 0, 0, 0, 0,  25,  0, 0, 0, 0);
    tbl[20] = mk(25, 1, 1, 0, 0,  25,  0, 0, 0, 0);
    tbl[21] = mk(25, 0, 0, 0, 0,  25,  0, 0, 0, 0);
    tbl[22] = mk(25, 1, 1, 0, 0,  25, 56, 0, 1, 1);
    tbl[23] = mk(25, 0, 0, 1, 0,  25, 56, 0, 1, 1);
    tbl[24] = mk(25, 1, 0, 0, 0,  25, 56, 0, 1, 1);

    #12;
    chk("reset.y", 16'(f0.y), 16'd0);
    chk("reset.v", 16'(f0.v), 16'd0);
    chk("reset.fall_valid", 16'(f0.fall_valid), 16'd0);
    chk("reset.airborne", 16'(air0), 16'd0);
    chk("reset.rising", 16'(rise0), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run_vec($sformatf("held%0d", i), mk(33, 1, 1, 0, 0, 33, 0, 0, 0, 0));
    run_vec("held_release", mk(33, 0, 1, 0, 0, 33, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < 25; i++) run_vec($sformatf("row%0d", i), tbl[i]);

    do_reset();
    run_vec("ceil_idle", mk(60, 0, 0, 0, 0, 60, 0, 0, 0, 0));
    chk("ceil_idle.u1.y", 16'(f1.y), 16'd60);
    run_vec("ceil_load", mk(60, 1, 1, 0, 0, 60, 56, 0, 1, 1));
    chk("ceil_load.u1.y", 16'(f1.y), 16'd60);
    chk("ceil_load.u1.v", 16'(f1.v), 16'd56);
    run_vec("ceil_step", mk(60, 0, 1, 0, 0, 109, 42, 0, 1, 1));
    chk("ceil_step.u1.y", 16'(f1.y), 16'd100);
    chk("ceil_step.u1.v", 16'(f1.v), 16'd0);
    chk("ceil_step.u1.fall_valid", 16'(f1.fall_valid), 16'd1);
    chk("ceil_step.u1.rising", 16'(rise1), 16'd0);

    #1 rst_n = 1'b0;
    #1;
    chk("areset.y", 16'(f0.y), 16'd0);
    chk("areset.v", 16'(f0.v), 16'd0);
    chk("areset.rising", 16'(rise0), 16'd0);
    chk("areset.airborne", 16'(air0), 16'd0);
    chk("areset.u1.fall_valid", 16'(f1.fall_valid), 16'd0);
    chk("areset.u1.y", 16'(f1.y), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jump_rise.md
# jump_rise

Vertical launch controller for the player sprite: detects a jump press, integrates the rising arc once per frame tick using the gravity constant shared with the free-fall stage, and hands the apex position/velocity to the free-fall stage over a valid/ready handshake. After handoff it waits for the collision logic's landing pulse, then enforces a re-jump cooldown. It is the upward counterpart of the free-fall integrator and produces that stage's initial position and velocity.

## Interface
- W, 9: position/velocity width
- G, 14: gravity per tick; must match the free-fall stage
- V_JUMP, 56: launch velocity loaded at jump start
- Y_CEIL, 400: maximum height; the arc saturates here
- COOLDOWN, 4: ticks after landing during which jump presses are ignored
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame-step strobe
- jump_req  in  1  jump button level, already synchronised
- y_ground  in  W  floor height under the sprite, unsigned
- land  in  1  one-cycle landing pulse from collision logic
- fall_ready  in  1  free-fall stage accepts the handoff
- fall_valid  out  1  handoff valid; y and v hold the free-fall initial values
- y  out  W  current height, unsigned
- v  out  W  current vertical velocity, two's complement, up is positive
- airborne  out  1  high whenever state is not GROUND
- rising  out  1  high in RISE

## Operation
- States: GROUND, RISE, HANDOFF, WAIT_LAND.
- Edge detection: jump_edge = jump_req & ~jump_q. jump_q resets to 1, so a button held through reset never launches.
- GROUND:
  - y <= y_ground every cycle; v = 0.
  - A jump_edge with cooldown = 0 sets pending.
  - On tick with (pending | accepted jump_edge): y <= y_ground, v <= V_JUMP, clear pending, go to RISE.
  - tick with cooldown > 0 decrements cooldown.
  - Edges during cooldown are dropped.
- RISE, on tick:
  - Compute y_n = y + v - G/2 at W+1 bits (G/2 truncated, 7 by default).
  - Compute v_n = v - G, signed, W bits.
  - If y_n > Y_CEIL: y <= Y_CEIL, v <= 0, go to HANDOFF (head bump).
  - Else: y <= y_n, v <= v_n; go to HANDOFF if v_n <= G (signed).
  - With no tick, hold y and v.
- HANDOFF:
  - fall_valid = 1; y and v held stable; tick ignored.
  - On fall_valid & fall_ready, go to WAIT_LAND.
- WAIT_LAND:
  - y and v hold their handoff values.
  - On land: go to GROUND, cooldown <= COOLDOWN.
- land outside WAIT_LAND is ignored.
- jump_edge outside GROUND is dropped; jumps are not buffered.

## Timing
- Reset values: state GROUND, y 0, v 0, fall_valid 0, airborne 0, rising 0, pending 0, cooldown 0, jump_q 1.
- From the first cycle after reset, y follows y_ground.
- All outputs are registered, with no combinational input-to-output path.
- Launch: the state change and the y/v load occur on the clock edge of the launching tick.
- Apex: fall_valid rises on the cycle after the tick that meets the apex or ceiling condition.
- Handshake: the transfer occurs on the edge where fall_valid & fall_ready are both high. fall_valid is low the next cycle, and airborne stays high.
- If fall_ready is already high on entry, HANDOFF lasts exactly one cycle.
- Async reset mid-arc: all outputs reach reset values immediately; no partial handoff.
- With defaults, the arc is 3 integration ticks: v 56→42→28→14, Δy 49, 35, 21.

## Structure
- Shared package jump_pkg holds:
  - the state enum
  - default G, W, V_JUMP
  - the G/2 constant
- The free-fall stage imports the same G.
- One sub-module, kin_step, is combinational. It takes y and v and outputs y_n, v_n, ceil_hit and apex, and contains all width-extended and signed arithmetic.
- The top level holds the FSM, edge detect, pending flag and cooldown counter.

## Test plan
- Held button through reset: hold jump_req=1 across reset, run 10 ticks -> state stays GROUND, y = y_ground, fall_valid never asserts.
- Nominal arc: y_ground=20, pulse jump_req, run 4 ticks -> y = 20, 69, 104, 125 and v = 56, 42, 28, 14; then fall_valid=1 with y=125, v=14.
- Backpressure: hold fall_ready=0 for 5 cycles and send ticks -> y=125, v=14 and fall_valid stay stable. Raise fall_ready -> one-cycle transfer, fall_valid=0, airborne=1.
- Ceiling: Y_CEIL=100, y_ground=60 -> after the load tick, the next tick gives y=100, v=0, fall_valid asserted.
- Cooldown: after land, jump edges on ticks 1-4 are ignored. An edge after the 4th tick launches on its tick.
- Async reset mid-arc: assert rst_n=0 during RISE -> y=0, v=0, rising=0, fall_valid=0 without waiting for a clock edge.
